fast_kp_arbiter: RTL and testbench

FAST_KP_ARBITER -- requirements
Module: fast_kp_arbiter

---
 rtl/fast_kp_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_fast_kp_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_kp_arbiter.sv
// fast_kp_arbiter
//
// Merges the keypoint streams of two FAST corner detectors into one
// valid/ready stream. Each detector feeds its own FIFO; a round-robin
// arbiter moves entries from the FIFOs into a single output register.
// A small frame FSM (IDLE -> RUN -> DRAIN -> DONE) tracks each frame.
//
// Optional feature: define KP_LIMIT_EN to add a per-frame keypoint cap
// (MAX_KP) and the limit_hit output.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   start                          frame-start pulse (flushes the datapath)
//   XYO_fast1 / wren_XYO_fast1     detector-1 keypoint {X,Y,O} and strobe
//   XYO_fast2 / wren_XYO_fast2     detector-2 keypoint {X,Y,O} and strobe
//   done_fast1 / done_fast2        per-detector end-of-frame pulses
//   kp_data / kp_valid / kp_ready  merged output {src, XYO} and handshake
//   num_fast1 / num_fast2          accepted keypoints per channel (saturating)
//   ovf1 / ovf2                    sticky FIFO-overflow drop flags
//   frame_done                     one-cycle end-of-frame pulse
//   limit_hit                      (KP_LIMIT_EN only) sticky cap-reached flag
module fast_kp_arbiter #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_KP     = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [21:0] XYO_fast1,
  input  logic        wren_XYO_fast1,
  input  logic [21:0] XYO_fast2,
  input  logic        wren_XYO_fast2,
  input  logic        done_fast1,
  input  logic        done_fast2,
  output logic [22:0] kp_data,
  output logic        kp_valid,
  input  logic        kp_ready,
  output logic [13:0] num_fast1,
  output logic [13:0] num_fast2,
  output logic        ovf1,
  output logic        ovf2,
  output logic        frame_done
`ifdef KP_LIMIT_EN
  ,
  output logic        limit_hit
`endif
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [13:0]   NUM_MAX  = 14'h3FFF;

  // Reject illegal configurations at elaboration time.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_KP < 1) begin : g_bad_param
    $error("fast_kp_arbiter: FIFO_DEPTH must be a power of two >= 2 and MAX_KP >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Per-channel storage and bookkeeping (index 0 = detector 1).
  logic [21:0]   mem_q    [2][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q [2];
  logic [AW-1:0] rd_ptr_q [2];
  logic [CW-1:0] cnt_q    [2];
  logic [CW-1:0] cnt_d    [2];

  logic [21:0] xyo_s [2];
  logic [1:0]  wren_s;
  logic [1:0]  empty_s;
  logic [1:0]  full_s;
  logic [1:0]  push_s;
  logic [1:0]  drop_s;
  logic [1:0]  pop_s;
  logic        grant_s;
  logic        out_free_s;
  logic        run_s;
  logic        cap_ok0_s;
  logic        cap_ok1_s;

  state_e      state_q;
  logic        seen1_q;
  logic        seen2_q;
  logic        frame_done_q;
  logic        last_q;
  logic        kp_valid_q;
  logic [22:0] kp_data_q;
  logic [13:0] num1_q;
  logic [13:0] num2_q;
  logic        ovf1_q;
  logic        ovf2_q;

`ifdef KP_LIMIT_EN
  localparam logic [14:0] MAX_KP_L = 15'(MAX_KP);
  logic [14:0] total_s;
  logic [14:0] total_d;
  logic        limit_hit_q;
`endif

  // Gather the two channel inputs into arrays and derive FIFO status.
  always_comb begin
    xyo_s[0]   = XYO_fast1;
    xyo_s[1]   = XYO_fast2;
    wren_s     = {wren_XYO_fast2, wren_XYO_fast1};
    empty_s[0] = (cnt_q[0] == {CW{1'b0}});
    empty_s[1] = (cnt_q[1] == {CW{1'b0}});
    full_s[0]  = (cnt_q[0] == FULL_CNT);
    full_s[1]  = (cnt_q[1] == FULL_CNT);
    out_free_s = !kp_valid_q || kp_ready;
    run_s      = (state_q == S_RUN);
  end

  // Round-robin grant: on a tie serve the channel not served last.
  always_comb begin
    pop_s   = 2'b00;
    grant_s = 1'b0;
    if (out_free_s && !empty_s[0] && !empty_s[1]) begin
      grant_s = ~last_q;
      pop_s   = last_q ? 2'b01 : 2'b10;
    end else if (out_free_s && !empty_s[0]) begin
      grant_s = 1'b0;
      pop_s   = 2'b01;
    end else if (out_free_s && !empty_s[1]) begin
      grant_s = 1'b1;
      pop_s   = 2'b10;
    end else begin
      grant_s = 1'b0;
      pop_s   = 2'b00;
    end
  end

`ifdef KP_LIMIT_EN
  // Running frame total used by the cap; channel 2 sees channel 1's same-cycle accept.
  always_comb begin
    total_s   = {1'b0, num1_q} + {1'b0, num2_q};
    cap_ok0_s = (total_s < MAX_KP_L);
    cap_ok1_s = ((total_s + {14'd0, push_s[0]}) < MAX_KP_L);
    total_d   = total_s + {14'd0, push_s[0]} + {14'd0, push_s[1]};
  end
`else
  // Without the cap every strobe is eligible.
  always_comb begin
    cap_ok0_s = 1'b1;
    cap_ok1_s = 1'b1;
  end
`endif

  // Accept or drop strobes; a full FIFO still accepts when it pops this cycle.
  always_comb begin
    push_s = 2'b00;
    drop_s = 2'b00;
    if (run_s && wren_s[0] && cap_ok0_s) begin
      if (!full_s[0] || pop_s[0]) begin
        push_s[0] = 1'b1;
      end else begin
        drop_s[0] = 1'b1;
      end
    end else begin
      push_s[0] = 1'b0;
    end
    if (run_s && wren_s[1] && cap_ok1_s) begin
      if (!full_s[1] || pop_s[1]) begin
        push_s[1] = 1'b1;
      end else begin
        drop_s[1] = 1'b1;
      end
    end else begin
      push_s[1] = 1'b0;
    end
  end

  // Next occupancy of each FIFO.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      case ({push_s[c], pop_s[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + CNT_ONE;
        2'b01:   cnt_d[c] = cnt_q[c] - CNT_ONE;
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
  end

  // FIFO payload storage; pointers alone define validity, so no reset needed.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push_s[c]) begin
        mem_q[c][wr_ptr_q[c]] <= xyo_s[c];
      end
    end
  end

  // FIFO pointers and occupancy; start empties both FIFOs.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst || start) begin
        wr_ptr_q[c] <= {AW{1'b0}};
        rd_ptr_q[c] <= {AW{1'b0}};
        cnt_q[c]    <= {CW{1'b0}};
      end else begin
        if (push_s[c]) begin
          wr_ptr_q[c] <= wr_ptr_q[c] + PTR_ONE;
        end
        if (pop_s[c]) begin
          rd_ptr_q[c] <= rd_ptr_q[c] + PTR_ONE;
        end
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  // Output register and round-robin pointer; start also re-arms the tie-break.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      kp_valid_q <= 1'b0;
      kp_data_q  <= 23'd0;
      last_q     <= 1'b1;
    end else if (pop_s != 2'b00) begin
      kp_valid_q <= 1'b1;
      kp_data_q  <= {grant_s, mem_q[grant_s][rd_ptr_q[grant_s]]};
      last_q     <= grant_s;
    end else if (kp_ready) begin
      kp_valid_q <= 1'b0;
    end
  end

  // Per-channel accept counters and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      num1_q <= 14'd0;
      num2_q <= 14'd0;
      ovf1_q <= 1'b0;
      ovf2_q <= 1'b0;
    end else begin
      if (push_s[0] && (num1_q != NUM_MAX)) begin
        num1_q <= num1_q + 14'd1;
      end
      if (push_s[1] && (num2_q != NUM_MAX)) begin
        num2_q <= num2_q + 14'd1;
      end
      if (drop_s[0]) begin
        ovf1_q <= 1'b1;
      end
      if (drop_s[1]) begin
        ovf2_q <= 1'b1;
      end
    end
  end

`ifdef KP_LIMIT_EN
  // Sticky flag raised once the frame total reaches the cap.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      limit_hit_q <= 1'b0;
    end else if (total_d >= MAX_KP_L) begin
      limit_hit_q <= 1'b1;
    end
  end
`endif

  // Frame FSM; done pulses may arrive in either order or together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      seen1_q      <= 1'b0;
      seen2_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (start) begin
      state_q      <= S_RUN;
      seen1_q      <= 1'b0;
      seen2_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          frame_done_q <= 1'b0;
        end
        S_RUN: begin
          seen1_q <= seen1_q | done_fast1;
          seen2_q <= seen2_q | done_fast2;
          if ((seen1_q || done_fast1) && (seen2_q || done_fast2)) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (empty_s[0] && empty_s[1] && !kp_valid_q) begin
            state_q      <= S_DONE;
            frame_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q      <= S_IDLE;
          frame_done_q <= 1'b0;
        end
        default: begin
          state_q      <= S_IDLE;
          frame_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign kp_data    = kp_data_q;
  assign kp_valid   = kp_valid_q;
  assign num_fast1  = num1_q;
  assign num_fast2  = num2_q;
  assign ovf1       = ovf1_q;
  assign ovf2       = ovf2_q;
  assign frame_done = frame_done_q;
`ifdef KP_LIMIT_EN
  assign limit_hit  = limit_hit_q;
`endif

endmodule

// File: tb/tb_fast_kp_arbiter.sv
// Directed bench for fast_kp_arbiter (FIFO_DEPTH=8, MAX_KP=5).
module tb_fast_kp_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [21:0] XYO_fast1 = 22'd0;
  logic        wren_XYO_fast1 = 1'b0;
  logic [21:0] XYO_fast2 = 22'd0;
  logic        wren_XYO_fast2 = 1'b0;
  logic        done_fast1 = 1'b0;
  logic        done_fast2 = 1'b0;
  logic [22:0] kp_data;
  logic        kp_valid;
  logic        kp_ready = 1'b0;
  logic [13:0] num_fast1;
  logic [13:0] num_fast2;
  logic        ovf1;
  logic        ovf2;
  logic        frame_done;
  logic        limit_hit;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  fast_kp_arbiter #(.FIFO_DEPTH(8), .MAX_KP(5)) dut (
    .clk(clk), .rst(rst), .start(start),
    .XYO_fast1(XYO_fast1), .wren_XYO_fast1(wren_XYO_fast1),
    .XYO_fast2(XYO_fast2), .wren_XYO_fast2(wren_XYO_fast2),
    .done_fast1(done_fast1), .done_fast2(done_fast2),
    .kp_data(kp_data), .kp_valid(kp_valid), .kp_ready(kp_ready),
    .num_fast1(num_fast1), .num_fast2(num_fast2),
    .ovf1(ovf1), .ovf2(ovf2), .frame_done(frame_done)
`ifdef KP_LIMIT_EN
    , .limit_hit(limit_hit)
`endif
  );

`ifndef KP_LIMIT_EN
  assign limit_hit = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [22:0] got_q[$];
  int hs;
  int fd;

  initial begin
    // Reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_eq("rst_valid", {31'd0, kp_valid}, 32'd0);
    check_eq("rst_data", {9'd0, kp_data}, 32'd0);
    check_eq("rst_num1", {18'd0, num_fast1}, 32'd0);
    check_eq("rst_num2", {18'd0, num_fast2}, 32'd0);
    check_eq("rst_ovf", {30'd0, ovf2, ovf1}, 32'd0);
    check_eq("rst_fdone", {31'd0, frame_done}, 32'd0);

    // Strobes in IDLE are ignored
    XYO_fast1 = 22'h000123; wren_XYO_fast1 = 1'b1;
    step();
    wren_XYO_fast1 = 1'b0;
    step(); step();
    check_eq("idle_num1", {18'd0, num_fast1}, 32'd0);
    check_eq("idle_valid", {31'd0, kp_valid}, 32'd0);

    // Single strobe latency
    kp_ready = 1'b1;
    pulse_start();
    XYO_fast1 = 22'h0A0284; wren_XYO_fast1 = 1'b1;
    step();
    wren_XYO_fast1 = 1'b0;
    check_eq("lat_n_valid", {31'd0, kp_valid}, 32'd0);
    step();
    check_eq("lat_n1_valid", {31'd0, kp_valid}, 32'd1);
    check_eq("lat_data", {9'd0, kp_data}, 32'h000A0284);
    check_eq("lat_num1", {18'd0, num_fast1}, 32'd1);
    step();
    check_eq("lat_consumed", {31'd0, kp_valid}, 32'd0);

    // Round-robin with both channels strobing every cycle
    pulse_start();
    got_q.delete();
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin
        XYO_fast1 = 22'h000100 + 22'(i); wren_XYO_fast1 = 1'b1;
        XYO_fast2 = 22'h000200 + 22'(i); wren_XYO_fast2 = 1'b1;
      end else begin
        wren_XYO_fast1 = 1'b0; wren_XYO_fast2 = 1'b0;
      end
      step();
      if (kp_valid) got_q.push_back(kp_data);
    end
    check_eq("rr_count", got_q.size(), 32'd8);
    for (int k = 0; k < got_q.size() && k < 8; k++) begin
      check_eq($sformatf("rr_item%0d", k), {9'd0, got_q[k]},
               (k % 2 == 1) ? (32'h00400200 + 32'(k / 2)) : (32'h00000100 + 32'(k / 2)));
    end
    check_eq("rr_ovf", {30'd0, ovf2, ovf1}, 32'd0);

    // Backpressure: fill register and FIFO, then overflow, then full+pop accept
    pulse_start();
    kp_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      XYO_fast2 = 22'h000300 + 22'(i); wren_XYO_fast2 = 1'b1;
      step();
    end
    check_eq("bp_held_valid", {31'd0, kp_valid}, 32'd1);
    check_eq("bp_held_data", {9'd0, kp_data}, 32'h00400300);
    check_eq("bp_num2_9", {18'd0, num_fast2}, 32'd9);
    check_eq("bp_no_ovf", {31'd0, ovf2}, 32'd0);
    XYO_fast2 = 22'h000309;
    step();
    check_eq("bp_ovf2", {31'd0, ovf2}, 32'd1);
    check_eq("bp_num2_drop", {18'd0, num_fast2}, 32'd9);
    got_q.delete();
    got_q.push_back(kp_data);
    kp_ready = 1'b1;
    XYO_fast2 = 22'h00030A;
    step();
    wren_XYO_fast2 = 1'b0;
    check_eq("bp_fullpop_num2", {18'd0, num_fast2}, 32'd10);
    for (int i = 0; i < 20 && kp_valid; i++) begin
      got_q.push_back(kp_data);
      step();
    end
    check_eq("bp_drain_count", got_q.size(), 32'd10);
    for (int k = 0; k < got_q.size() && k < 10; k++) begin
      check_eq($sformatf("bp_item%0d", k), {9'd0, got_q[k]},
               32'h00400300 + ((k == 9) ? 32'd10 : 32'(k)));
    end

    // Done pulses with 3 entries pending, then drain to frame_done
    pulse_start();
    kp_ready = 1'b0;
    XYO_fast1 = 22'h000400; wren_XYO_fast1 = 1'b1;
    XYO_fast2 = 22'h000500; wren_XYO_fast2 = 1'b1;
    step();
    XYO_fast1 = 22'h000401; wren_XYO_fast2 = 1'b0;
    step();
    wren_XYO_fast1 = 1'b0;
    done_fast2 = 1'b1;
    step();
    done_fast2 = 1'b0; done_fast1 = 1'b1;
    step();
    done_fast1 = 1'b0;
    check_eq("dn_no_early_fd", {31'd0, frame_done}, 32'd0);
    kp_ready = 1'b1;
    hs = 0; fd = 0;
    got_q.delete();
    for (int i = 0; i < 15; i++) begin
      if (kp_valid) begin hs++; got_q.push_back(kp_data); end
      if (frame_done) begin
        fd++;
        check_eq("dn_fd_after_hs", hs, 32'd3);
      end
      step();
    end
    check_eq("dn_hs", hs, 32'd3);
    check_eq("dn_fd_pulses", fd, 32'd1);
    if (got_q.size() == 3) begin
      check_eq("dn_item0", {9'd0, got_q[0]}, 32'h00000400);
      check_eq("dn_item1", {9'd0, got_q[1]}, 32'h00400500);
      check_eq("dn_item2", {9'd0, got_q[2]}, 32'h00000401);
    end
    XYO_fast1 = 22'h000777; wren_XYO_fast1 = 1'b1;
    step();
    wren_XYO_fast1 = 1'b0;
    step(); step();
    check_eq("dn_idle_num1", {18'd0, num_fast1}, 32'd2);
    check_eq("dn_idle_valid", {31'd0, kp_valid}, 32'd0);

    // Reset mid-frame
    pulse_start();
    kp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      XYO_fast1 = 22'h000600 + 22'(i); wren_XYO_fast1 = 1'b1;
      XYO_fast2 = 22'h000700 + 22'(i); wren_XYO_fast2 = 1'b1;
      step();
    end
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check_eq("mr_valid", {31'd0, kp_valid}, 32'd0);
    check_eq("mr_num1", {18'd0, num_fast1}, 32'd0);
    check_eq("mr_num2", {18'd0, num_fast2}, 32'd0);
    kp_ready = 1'b1;
    step(); step();
    wren_XYO_fast1 = 1'b0; wren_XYO_fast2 = 1'b0;
    step(); step();
    check_eq("mr_ign_valid", {31'd0, kp_valid}, 32'd0);
    check_eq("mr_ign_num", {4'd0, num_fast2, num_fast1}, 32'd0);
    pulse_start();
    XYO_fast1 = 22'h000055; wren_XYO_fast1 = 1'b1;
    step();
    wren_XYO_fast1 = 1'b0;
    step();
    check_eq("mr_restart_data", {9'd0, kp_data}, 32'h00000055);
    check_eq("mr_restart_num1", {18'd0, num_fast1}, 32'd1);

`ifdef KP_LIMIT_EN
    // Per-frame cap at MAX_KP=5
    pulse_start();
    check_eq("cap_clear", {31'd0, limit_hit}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      XYO_fast1 = 22'h000800 + 22'(i); wren_XYO_fast1 = 1'b1;
      step();
    end
    wren_XYO_fast1 = 1'b0;
    step(); step();
    check_eq("cap_num1", {18'd0, num_fast1}, 32'd5);
    check_eq("cap_hit", {31'd0, limit_hit}, 32'd1);
    check_eq("cap_ovf1", {31'd0, ovf1}, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
